// File: rtl/sprite_pkg.sv
// Shared sprite geometry, palette sizing and colour type for the sprite fetch pipeline.
package sprite_pkg;
    localparam int SPR_W     = 64;
    localparam int SPR_H     = 64;
    localparam int ADDR_W    = 12;
    localparam int PIX_IDX_W = 4;
    localparam int PAL_N     = 1 << PIX_IDX_W;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;
endpackage

// File: rtl/sprite_palette.sv
// 16-entry colour palette: one write port, one registered read port.
// A read and a write of the same entry in one cycle returns the old colour.
module sprite_palette
    import sprite_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [PIX_IDX_W-1:0] wr_idx,
    input  rgb_t                 wr_rgb,
    input  logic [PIX_IDX_W-1:0] rd_idx,
    output rgb_t                 rd_rgb
);
    rgb_t mem [PAL_N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAL_N; i++) mem[i] <= '0;
            rd_rgb <= '0;
        end else begin
            if (we) mem[wr_idx] <= wr_rgb;
            rd_rgb <= mem[rd_idx];
        end
    end
endmodule

// File: rtl/sprite_fetch.sv
// Sprite pixel fetch: hit test against a frame-latched position, external RAM read,
// palette lookup. Four cycles from DrawX/DrawY to the pix_* outputs.
module sprite_fetch #(
    parameter int SPR_W  = sprite_pkg::SPR_W,
    parameter int SPR_H  = sprite_pkg::SPR_H,
    parameter int ADDR_W = sprite_pkg::ADDR_W
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic [9:0]                      DrawX,
    input  logic [9:0]                      DrawY,
    input  logic                            blank,
    input  logic                            vs,
    input  logic [9:0]                      SpriteX,
    input  logic [9:0]                      SpriteY,
    output logic [ADDR_W-1:0]               rd_addr,
    output logic                            rd_en,
    input  logic [sprite_pkg::PIX_IDX_W-1:0] rd_data,
    input  logic                            pal_we,
    input  logic [sprite_pkg::PIX_IDX_W-1:0] pal_idx,
    input  logic [23:0]                     pal_rgb,
    output logic                            pix_valid,
    output logic [7:0]                      pix_red,
    output logic [7:0]                      pix_green,
    output logic [7:0]                      pix_blue
);
    import sprite_pkg::*;

    localparam int LOG_W = $clog2(SPR_W);

    logic              vs_q, vs_fall;
    logic [9:0]        sh_x, sh_y;
    logic [10:0]       x_ext, y_ext, x_lo, y_lo, dx, dy;
    logic [10+LOG_W:0] lin;
    logic              hit;
    logic [3:1]        vld_pipe;
    rgb_t              pal_out;

    // Position is sampled once per frame so the sprite cannot tear mid-scan.
    assign vs_fall = vs_q & ~vs;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_q <= 1'b0;
            sh_x <= '0;
            sh_y <= '0;
        end else begin
            vs_q <= vs;
            if (vs_fall) begin
                sh_x <= SpriteX;
                sh_y <= SpriteY;
            end
        end
    end

    // 11-bit bounds so a sprite near the right/bottom edge clips instead of wrapping.
    always_comb begin
        x_ext = {1'b0, DrawX};
        y_ext = {1'b0, DrawY};
        x_lo  = {1'b0, sh_x};
        y_lo  = {1'b0, sh_y};
        hit   = blank
              && (x_ext >= x_lo) && (x_ext < x_lo + 11'(SPR_W))
              && (y_ext >= y_lo) && (y_ext < y_lo + 11'(SPR_H));
        dx    = x_ext - x_lo;
        dy    = y_ext - y_lo;
        lin   = {dy, {LOG_W{1'b0}}} + {{LOG_W{1'b0}}, dx};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_addr  <= '0;
            vld_pipe <= '0;
        end else begin
            if (hit) rd_addr <= ADDR_W'(lin);
            vld_pipe <= {vld_pipe[2:1], hit};
        end
    end

    assign rd_en = vld_pipe[1];

    // Stage 3 flag lines up with rd_data; index 0 is the transparent colour.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) pix_valid <= 1'b0;
        else          pix_valid <= vld_pipe[3] && (rd_data != '0);
    end

    sprite_palette u_palette (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .we     (pal_we),
        .wr_idx (pal_idx),
        .wr_rgb (rgb_t'(pal_rgb)),
        .rd_idx (rd_data),
        .rd_rgb (pal_out)
    );

    assign pix_red   = pix_valid ? pal_out.r : 8'd0;
    assign pix_green = pix_valid ? pal_out.g : 8'd0;
    assign pix_blue  = pix_valid ? pal_out.b : 8'd0;
endmodule

// File: tb/tb_sprite_fetch.sv
// Bench for sprite_fetch: fixed vectors and corner sequences plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_sprite_fetch;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic [9:0]  DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
    logic        blank = 1'b0, vs = 1'b1;
    logic [11:0] rd_addr;
    logic        rd_en;
    logic [3:0]  rd_data;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_idx = '0;
    logic [23:0] pal_rgb = '0;
    logic        pix_valid;
    logic [7:0]  pix_red, pix_green, pix_blue;

    always #5 Clk = ~Clk;

    sprite_fetch dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .vs(vs),
        .SpriteX(SpriteX), .SpriteY(SpriteY), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_data(rd_data), .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
        .pix_valid(pix_valid), .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue)
    );

    // External sprite RAM: registered address, registered data.
    logic [3:0]  mem [4096];
    logic [11:0] ram_a = '0;
    always @(posedge Clk) begin
        ram_a   <= rd_addr;
        rd_data <= mem[ram_a];
    end

    // Reference model state
    typedef struct packed { logic hit; logic [3:0] idx; } slot_t;
    int          sh_x, sh_y;
    bit          prev_vs;
    logic [23:0] pal [16];
    int          m_addr;
    bit          m_en;
    logic [24:0] m_pix;
    slot_t       pend [$];
    int          tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        sh_x = 0; sh_y = 0; prev_vs = 0;
        for (int i = 0; i < 16; i++) pal[i] = '0;
        m_addr = 0; m_en = 0; m_pix = '0;
        pend.delete();
    endfunction

    task automatic model_edge();
        int x, y;
        bit h;
        slot_t s;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        x = int'(DrawX); y = int'(DrawY);
        h = blank && x >= sh_x && x < sh_x + 64 && y >= sh_y && y < sh_y + 64;
        m_en = h;
        if (h) m_addr = (y - sh_y) * 64 + (x - sh_x);
        s.hit = h;
        s.idx = h ? mem[m_addr] : 4'd0;
        pend.push_back(s);
        if (pend.size() == 4) begin
            s = pend.pop_front();
            m_pix = (s.hit && s.idx != 0) ? {1'b1, pal[s.idx]} : 25'd0;
        end
        if (pal_we) pal[pal_idx] = pal_rgb;
        if (prev_vs && !vs) begin
            sh_x = int'(SpriteX);
            sh_y = int'(SpriteY);
        end
        prev_vs = vs;
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check("rd_en", 32'(rd_en), 32'(m_en));
        check("rd_addr", 32'(rd_addr), 32'(m_addr));
        check("pix", 32'({pix_valid, pix_red, pix_green, pix_blue}), 32'(m_pix));
    endtask

    task automatic latch(input int x, input int y);
        SpriteX = 10'(x); SpriteY = 10'(y);
        vs = 1'b1; step();
        vs = 1'b0; step();
        vs = 1'b1; step();
    endtask

    task automatic pix_after(input int x, input int y, input logic [24:0] exp, input string name);
        DrawX = 10'(x); DrawY = 10'(y); blank = 1'b1; step();
        blank = 1'b0; step(); step(); step();
        check(name, 32'({pix_valid, pix_red, pix_green, pix_blue}), 32'(exp));
    endtask

    typedef struct { int x; int y; bit bl; bit en; int addr; } vec_t;
    vec_t tbl [11];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 4'($urandom_range(0, 15));
        mem[0] = 4'd5; mem[1] = 4'd0; mem[650] = 4'd7;
        model_reset();

        // Reset state
        #2 Reset_n = 1'b0;
        #1;
        check("reset_en", 32'(rd_en), 0);
        check("reset_addr", 32'(rd_addr), 0);
        check("reset_pix", 32'({pix_valid, pix_red, pix_green, pix_blue}), 0);
        step(); step();
        Reset_n = 1'b1;
        step();

        // Palette load
        for (int i = 0; i < 16; i++) begin
            pal_we = 1'b1; pal_idx = 4'(i);
            pal_rgb = (i == 5) ? 24'hFF8000 : 24'($urandom);
            step();
        end
        pal_we = 1'b0;

        latch(100, 50);

        tbl[0]  = '{100, 50, 1, 1, 0};
        tbl[1]  = '{163, 113, 1, 1, 4095};
        tbl[2]  = '{164, 113, 1, 0, 4095};
        tbl[3]  = '{99, 50, 1, 0, 4095};
        tbl[4]  = '{101, 50, 1, 1, 1};
        tbl[5]  = '{110, 60, 0, 0, 1};
        tbl[6]  = '{163, 50, 1, 1, 63};
        tbl[7]  = '{100, 113, 1, 1, 4032};
        tbl[8]  = '{100, 114, 1, 0, 4032};
        tbl[9]  = '{100, 49, 1, 0, 4032};
        tbl[10] = '{0, 0, 1, 0, 4032};
        for (int i = 0; i < 11; i++) begin
            DrawX = 10'(tbl[i].x); DrawY = 10'(tbl[i].y); blank = tbl[i].bl;
            step();
            check($sformatf("tbl%0d_en", i), 32'(rd_en), 32'(tbl[i].en));
            check($sformatf("tbl%0d_addr", i), 32'(rd_addr), 32'(tbl[i].addr));
        end

        // Opaque, transparent and the right-hand miss, four cycles later
        pix_after(100, 50, {1'b1, 24'hFF8000}, "pix_ff8000");
        pix_after(101, 50, 25'd0, "pix_transparent");
        pix_after(164, 113, 25'd0, "pix_outside");

        // Palette write in the same cycle as the lookup returns the old colour
        DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1; step();
        blank = 1'b0; step(); step();
        pal_we = 1'b1; pal_idx = 4'd5; pal_rgb = 24'h123456; step();
        pal_we = 1'b0;
        check("rbw_old", 32'({pix_valid, pix_red, pix_green, pix_blue}), 32'({1'b1, 24'hFF8000}));
        pix_after(100, 50, {1'b1, 24'h123456}, "rbw_new");

        // Mid-frame move is deferred to the next vs fall
        SpriteX = 10'd200;
        DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1; step();
        check("tear_old_hit", 32'(rd_en), 1);
        DrawX = 10'd200; step();
        check("tear_new_early", 32'(rd_en), 0);
        latch(200, 50);
        DrawX = 10'd200; DrawY = 10'd50; blank = 1'b1; step();
        check("tear_new_hit", 32'(rd_en), 1);
        DrawX = 10'd100; step();
        check("tear_old_gone", 32'(rd_en), 0);

        // Right-edge clipping
        latch(620, 50);
        blank = 1'b1; DrawY = 10'd60;
        for (int x = 610; x < 640; x++) begin
            DrawX = 10'(x); step();
            check($sformatf("clip_x%0d", x), 32'(rd_en), 32'(x >= 620));
        end
        for (int x = 0; x < 4; x++) begin
            DrawX = 10'(x); step();
            check($sformatf("nowrap_x%0d", x), 32'(rd_en), 0);
        end

        // Reset while hits are in flight; vs held low through release must not latch
        latch(100, 50);
        blank = 1'b1; DrawY = 10'd50;
        for (int x = 100; x < 104; x++) begin DrawX = 10'(x); step(); end
        Reset_n = 1'b0; vs = 1'b0; SpriteX = 10'd300; SpriteY = 10'd300;
        model_reset();
        #1;
        check("rst_async_en", 32'(rd_en), 0);
        check("rst_async_addr", 32'(rd_addr), 0);
        check("rst_async_pix", 32'({pix_valid, pix_red, pix_green, pix_blue}), 0);
        step(); step();
        Reset_n = 1'b1;
        DrawX = 10'd10; DrawY = 10'd10;
        step();
        check("vs_low_no_latch", 32'(rd_en), 1);
        step(); step();
        check("squash_pix", 32'(pix_valid), 0);
        step();
        check("pal_cleared", 32'({pix_valid, pix_red, pix_green, pix_blue}), 32'({1'b1, 24'h0}));
        vs = 1'b1; step();

        // Randomized traffic against the model
        for (int i = 0; i < 16; i++) begin
            pal_we = 1'b1; pal_idx = 4'(i); pal_rgb = 24'($urandom); step();
        end
        pal_we = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            int bx, by;
            if ($urandom_range(0, 3) != 0) begin
                bx = sh_x - 4 + int'($urandom_range(0, 72));
                by = sh_y - 4 + int'($urandom_range(0, 72));
            end else begin
                bx = int'($urandom_range(0, 1023));
                by = int'($urandom_range(0, 1023));
            end
            DrawX = 10'((bx < 0) ? 0 : (bx > 1023 ? 1023 : bx));
            DrawY = 10'((by < 0) ? 0 : (by > 1023 ? 1023 : by));
            blank = ($urandom_range(0, 9) != 0);
            vs = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 49) == 0) begin
                SpriteX = 10'($urandom_range(0, 639));
                SpriteY = 10'($urandom_range(0, 479));
            end
            pal_we = ($urandom_range(0, 9) == 0);
            pal_idx = 4'($urandom);
            pal_rgb = 24'($urandom);
            Reset_n = ($urandom_range(0, 999) != 0);
            step();
        end
        Reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 SHALL have parameter SPR_W, 64: sprite width in pixels, a power of two.
REQ-002 SHALL have parameter SPR_H, 64: sprite height in pixels.
REQ-003 SHALL have parameter ADDR_W, 12: sprite RAM address width, log2(SPR_W*SPR_H).
REQ-004 SHALL have port Clk  input  1  system clock, the same clock as the VGA controller; all logic on the rising edge.
REQ-005 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port DrawX  input  10  current pixel column from the VGA controller.
REQ-007 SHALL have port DrawY  input  10  current pixel row.
REQ-008 SHALL have port blank  input  1  active-low blanking; 0 = not displaying.
REQ-009 SHALL have port vs  input  1  vertical sync, active-low.
REQ-010 SHALL have port SpriteX  input  10  sprite top-left column, live value from the motion block.
REQ-011 SHALL have port SpriteY  input  10  sprite top-left row, live value.
REQ-012 SHALL have port rd_addr  output  ADDR_W  sprite RAM read address.
REQ-013 SHALL have port rd_en  output  1  sprite RAM read enable.
REQ-014 SHALL have port rd_data  input  4  palette index returned by the RAM.
REQ-015 SHALL have port pal_we  input  1  palette write strobe.
REQ-016 SHALL have port pal_idx  input  4  palette entry to write.
REQ-017 SHALL have port pal_rgb  input  24  {R,G,B} data to write.
REQ-018 SHALL have port pix_valid  output  1  output pixel is inside the sprite and opaque.
REQ-019 SHALL have ports pix_red, pix_green, pix_blue  output  8 each  colour for the color mapper.

Function
REQ-020 SHALL register SpriteX/SpriteY into shadow registers in the cycle after a detected vs 1->0 transition; all hit tests SHALL use the shadow values only, so the sprite never tears mid-frame.
REQ-021 SHALL compute hit = blank & (DrawX>=shX) & (DrawX<shX+SPR_W) & (DrawY>=shY) & (DrawY<shY+SPR_H), using 11-bit sums with no wrap-around.
REQ-022 SHALL drive rd_addr = (DrawY-shY)*SPR_W + (DrawX-shX) and rd_en = hit, both registered, one cycle after DrawX/DrawY are sampled (stage 1).
REQ-023 SHALL hold rd_addr at its previous value when hit=0.
REQ-024 SHALL treat rd_data as valid two cycles after rd_addr (stage 3), matching a RAM with registered address and registered output.
REQ-025 SHALL delay the hit flag through stages 1-3 so it aligns with rd_data.
REQ-026 SHALL register the palette lookup at stage 4, making total latency exactly 4 cycles from DrawX/DrawY to the pix_* outputs.
REQ-027 SHALL make palette index 0 transparent: pix_valid=0 and RGB=0.
REQ-028 SHALL output pix_valid=0 and RGB=0 when the delayed hit flag is 0.
REQ-029 SHALL hold a 16x24 palette in registers and write entry pal_idx on each cycle with pal_we=1.
REQ-030 SHALL use the old palette value for a lookup of the same entry in the same cycle as a write (read-before-write); the new value SHALL apply from the next cycle.
REQ-031 SHALL clip a sprite that extends past column 639 or row 479 naturally, with no wrap to column/row 0.
REQ-032 SHALL treat consecutive vs falls each as a new latch, with no debounce.

Reset
REQ-033 SHALL, while Reset_n=0, asynchronously clear rd_en=0, rd_addr=0, pix_valid=0, pix_*=0, the shadow positions, the pipeline flags and all palette entries.
REQ-034 SHALL squash a pixel that was in flight at reset assertion: the first valid output after reset release SHALL be no earlier than 4 cycles after release.
REQ-035 SHALL clear the vs edge detector on reset; a vs already low at reset release SHALL NOT latch.

Structure
REQ-036 SHALL take SPR_W, SPR_H, ADDR_W, PIX_IDX_W=4 and the rgb_t struct (8-bit r, g, b) from a shared sprite_pkg package.
REQ-037 SHALL contain one sub-module, sprite_palette (16-entry register file with write port and registered read).
REQ-038 SHALL NOT contain the sprite RAM; the RAM SHALL be external on the rd_* ports.

Verification
REQ-039 SHALL pass this case: shadow (100,50), DrawX=100 DrawY=50 blank=1 -> rd_addr=0 and rd_en=1 at +1 cycle; pix_* valid at +4 cycles.
REQ-040 SHALL pass this case: DrawX=163 DrawY=113 -> rd_addr=4095; DrawX=164 -> rd_en=0 and pix_valid=0 at +4 cycles.
REQ-041 SHALL pass this case: rd_data=0 inside the sprite -> pix_valid=0 and RGB=0; rd_data=5 with palette[5]=24'hFF8000 -> pix_red=FF, pix_green=80, pix_blue=00.
REQ-042 SHALL pass this case: SpriteX changes 100->200 mid-frame -> hits stay at column 100 until the next vs fall, then move to 200.
REQ-043 SHALL pass this case: SpriteX=620 -> columns 620-639 hit and column 0 never hits.
REQ-044 SHALL pass this case: Reset_n pulsed low while hits are in flight -> outputs are 0 immediately, the palette reads 0, and no stale pix_valid appears after release.
